// File: rtl/operand_sequencer_pkg.sv
// Shared types and constants for the operand sequencer and its table.
package operand_sequencer_pkg;

  localparam int unsigned ROWS = 4;
  localparam int unsigned COLS = 4;
  localparam int unsigned NENT = 16;
  localparam int unsigned IDXW = 4;
  localparam int unsigned ROWW = 2;
  localparam int unsigned COLW = 2;
  localparam int unsigned DW   = 8;

  typedef logic [DW-1:0] uint8_t;
  typedef uint8_t [ROWS-1:0][COLS-1:0] table_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_e;

  // Power-on content of entry [r][c] is its row-major index.
  function automatic uint8_t init_entry(input int unsigned r, input int unsigned c);
    return DW'(r * COLS + c);
  endfunction

endpackage

// File: rtl/operand_table.sv
// 4x4 byte register file: reset to index pattern, one write port, two async read ports.
module operand_table
  import operand_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [ROWW-1:0] wr_row,
  input  logic [COLW-1:0] wr_col,
  input  uint8_t          wr_data,
  input  logic [IDXW-1:0] rd_idx_a,
  input  logic [IDXW-1:0] rd_idx_b,
  output uint8_t          rd_a_c,
  output uint8_t          rd_b_c
);

  table_t mem;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        for (int unsigned c = 0; c < COLS; c++) begin
          mem[r][c] <= init_entry(r, c);
        end
      end
    end else if (wr_en) begin
      mem[wr_row][wr_col] <= wr_data;
    end
  end

  assign rd_a_c = mem[rd_idx_a[IDXW-1:COLW]][rd_idx_a[COLW-1:0]];
  assign rd_b_c = mem[rd_idx_b[IDXW-1:COLW]][rd_idx_b[COLW-1:0]];

endmodule

// File: rtl/operand_sequencer.sv
// Sweeps the operand table NPASS times, presenting (table[i], table[i+STRIDE]) pairs
// on a valid/ready handshake and accumulating a mod-256 checksum of A+B.
module operand_sequencer
  import operand_sequencer_pkg::*;
#(
  parameter int unsigned NPASS  = 1,
  parameter int unsigned STRIDE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            wr_en,
  input  logic [ROWW-1:0] wr_row,
  input  logic [COLW-1:0] wr_col,
  input  uint8_t          wr_data,
  output uint8_t          a,
  output uint8_t          b,
  output logic            valid,
  input  logic            ready,
  output logic            last,
  output logic            busy,
  output logic            done,
  output uint8_t          csum,
  output logic            wr_err
);

  state_e          state, state_d;
  logic [IDXW-1:0] idx, idx_d;
  logic [IDXW-1:0] pass, pass_d;
  uint8_t          a_d, b_d, csum_d;
  logic            valid_d, last_d, load;

  logic            wr_fire;
  logic [IDXW-1:0] wr_idx, rd_idx_b;
  uint8_t          rd_a_c, rd_b_c;

  assign wr_fire  = wr_en && (state == IDLE);
  assign wr_idx   = {wr_row, wr_col};
  assign rd_idx_b = IDXW'(idx_d + IDXW'(STRIDE));

  operand_table u_table (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_fire),
    .wr_row   (wr_row),
    .wr_col   (wr_col),
    .wr_data  (wr_data),
    .rd_idx_a (idx_d),
    .rd_idx_b (rd_idx_b),
    .rd_a_c   (rd_a_c),
    .rd_b_c   (rd_b_c)
  );

  // Bypass a same-cycle IDLE write so a START+WR_EN sweep sees the new value.
  function automatic uint8_t fwd(input logic [IDXW-1:0] ri, input uint8_t rd);
    return (wr_fire && (ri == wr_idx)) ? wr_data : rd;
  endfunction

  always_comb begin
    state_d = state;
    idx_d   = idx;
    pass_d  = pass;
    csum_d  = csum;
    valid_d = valid;
    last_d  = last;
    load    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          idx_d   = '0;
          pass_d  = '0;
          csum_d  = '0;
          valid_d = 1'b1;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (valid && ready) begin
          csum_d = csum + a + b;
          if (last) begin
            state_d = FIN;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            load = 1'b1;
            if (idx == IDXW'(NENT - 1)) begin
              idx_d  = '0;
              pass_d = pass + IDXW'(1);
            end else begin
              idx_d = idx + IDXW'(1);
            end
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
    if (load) begin
      last_d = (idx_d == IDXW'(NENT - 1)) && (pass_d == IDXW'(NPASS - 1));
    end
    a_d = load ? fwd(idx_d, rd_a_c) : a;
    b_d = load ? fwd(rd_idx_b, rd_b_c) : b;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      pass   <= '0;
      a      <= '0;
      b      <= '0;
      valid  <= 1'b0;
      last   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      csum   <= '0;
      wr_err <= 1'b0;
    end else begin
      state  <= state_d;
      idx    <= idx_d;
      pass   <= pass_d;
      a      <= a_d;
      b      <= b_d;
      valid  <= valid_d;
      last   <= last_d;
      busy   <= (state_d != IDLE);
      done   <= (state_d == FIN);
      csum   <= csum_d;
      wr_err <= wr_en && (state != IDLE);
    end
  end

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer: default-parameter sweeps plus an NPASS=2 instance.
module tb_operand_sequencer;
  import operand_sequencer_pkg::*;

  logic       clk, rst, start, wr_en, ready;
  logic [1:0] wr_row, wr_col;
  logic [7:0] wr_data;

  logic [7:0] a1, b1, csum1, a2, b2, csum2;
  logic       valid1, last1, busy1, done1, wr_err1;
  logic       valid2, last2, busy2, done2, wr_err2;

  int errors = 0;
  int checks = 0;
  logic [7:0] model [16];

  operand_sequencer #(.NPASS(1), .STRIDE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .wr_en(wr_en), .wr_row(wr_row),
    .wr_col(wr_col), .wr_data(wr_data), .a(a1), .b(b1), .valid(valid1),
    .ready(ready), .last(last1), .busy(busy1), .done(done1), .csum(csum1),
    .wr_err(wr_err1)
  );

  operand_sequencer #(.NPASS(2), .STRIDE(1)) dut2 (
    .clk(clk), .rst(rst), .start(start), .wr_en(wr_en), .wr_row(wr_row),
    .wr_col(wr_col), .wr_data(wr_data), .a(a2), .b(b2), .valid(valid2),
    .ready(ready), .last(last2), .busy(busy2), .done(done2), .csum(csum2),
    .wr_err(wr_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model[i] = 8'(i);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One NPASS=1 sweep on dut, optional READY stall, in-RUN write, and START+write.
  task automatic run1(input int stall_idx, input int stall_cyc, input int err_at,
                      input bit do_wr, input logic [1:0] r, input logic [1:0] c,
                      input logic [7:0] d, input logic [7:0] exp_csum);
    start = 1'b1;
    if (do_wr) begin
      wr_en = 1'b1; wr_row = r; wr_col = c; wr_data = d;
      model[{r, c}] = d;
    end
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b0;
    for (int k = 0; k < 16; k++) begin
      wr_en = (k == err_at);
      if (k == err_at) begin
        wr_row = 2'd0; wr_col = 2'd0; wr_data = 8'd99;
      end
      if (k == stall_idx) begin
        ready = 1'b0;
        repeat (stall_cyc) begin
          @(negedge clk);
          check("hold_valid", valid1, 1);
          check("hold_a", a1, model[k]);
          check("hold_b", b1, model[(k + 1) % 16]);
        end
        ready = 1'b1;
      end
      check("valid", valid1, 1);
      check("a", a1, model[k]);
      check("b", b1, model[(k + 1) % 16]);
      check("last", last1, (k == 15));
      check("wr_err", wr_err1, (err_at >= 0) && (k == err_at + 1));
      @(negedge clk);
    end
    wr_en = 1'b0;
    check("done_pulse", done1, 1);
    check("fin_busy", busy1, 1);
    check("fin_valid", valid1, 0);
    check("csum", csum1, exp_csum);
    @(negedge clk);
    check("done_clear", done1, 0);
    check("idle_busy", busy1, 0);
    check("csum_hold", csum1, exp_csum);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; wr_en = 1'b0; ready = 1'b1;
    wr_row = '0; wr_col = '0; wr_data = '0;
    do_reset();

    check("rst_valid", valid1, 0);
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_last", last1, 0);
    check("rst_a", a1, 0);
    check("rst_b", b1, 0);
    check("rst_csum", csum1, 0);
    check("rst_wr_err", wr_err1, 0);

    // Plain sweep: sum of i + (i+1)%16 over 16 entries = 240.
    run1(-1, 0, -1, 1'b0, 2'd0, 2'd0, 8'd0, 8'd240);

    // Three-cycle READY stall on pair (2,3).
    do_reset();
    run1(2, 3, -1, 1'b0, 2'd0, 2'd0, 8'd0, 8'd240);

    // IDLE write [1][2]=200: pairs (5,200),(200,7), csum 628 mod 256 = 116.
    do_reset();
    wr_en = 1'b1; wr_row = 2'd1; wr_col = 2'd2; wr_data = 8'd200;
    @(negedge clk);
    wr_en = 1'b0;
    model[6] = 8'd200;
    check("wr_err_idle", wr_err1, 0);
    run1(-1, 0, -1, 1'b0, 2'd0, 2'd0, 8'd0, 8'd116);

    // START together with write [0][0]=50: first pair (50,1), csum 340 mod 256 = 84.
    do_reset();
    run1(-1, 0, -1, 1'b1, 2'd0, 2'd0, 8'd50, 8'd84);

    // Write during RUN is dropped and flagged; next sweep still starts (0,1).
    do_reset();
    run1(-1, 0, 3, 1'b0, 2'd0, 2'd0, 8'd0, 8'd240);
    run1(-1, 0, -1, 1'b0, 2'd0, 2'd0, 8'd0, 8'd240);

    // Reset mid-sweep after 7 transfers wipes state and an earlier write.
    do_reset();
    wr_en = 1'b1; wr_row = 2'd2; wr_col = 2'd3; wr_data = 8'd77;
    @(negedge clk);
    wr_en = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("pre_rst_csum", csum1, 8'd49);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", valid1, 0);
    check("midrst_busy", busy1, 0);
    check("midrst_csum", csum1, 0);
    rst = 1'b0;
    model_reset();
    run1(-1, 0, -1, 1'b0, 2'd0, 2'd0, 8'd0, 8'd240);

    // NPASS=2 instance: 32 transfers, LAST only on the 32nd, csum 480 mod 256 = 224.
    do_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      check("p2_valid", valid2, 1);
      check("p2_a", a2, 8'(k % 16));
      check("p2_b", b2, 8'((k + 1) % 16));
      check("p2_last", last2, (k == 31));
      check("p2_done", done2, 0);
      @(negedge clk);
    end
    check("p2_done_pulse", done2, 1);
    check("p2_csum", csum2, 8'd224);
    @(negedge clk);
    check("p2_done_clear", done2, 0);
    check("p2_busy", busy2, 0);
    check("p2_valid_idle", valid2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/operand_sequencer.md
OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

Interface
REQ-001 SHALL have parameter NPASS, default 1: number of full 16-entry sweeps per START (1..15).
REQ-002 SHALL have parameter STRIDE, default 1: table offset of the B operand relative to A (0..15).
REQ-003 SHALL have port CLK  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port START  in  1  sweep request, sampled in IDLE only.
REQ-006 SHALL have ports WR_EN in 1, WR_ROW in 2, WR_COL in 2, WR_DATA in 8: table write port.
REQ-007 SHALL have ports A out 8, B out 8: unsigned operand pair for the downstream stage.
REQ-008 SHALL have ports VALID out 1, READY in 1: operand handshake.
REQ-009 SHALL have ports LAST out 1, BUSY out 1, DONE out 1, CSUM out 8, WR_ERR out 1.

Function
REQ-010 SHALL hold a 4x4 table of 8-bit unsigned entries, row-major index i = row*4+col.
REQ-011 SHALL initialise entry [r][c] to r*4+c on reset.
REQ-012 SHALL implement FSM states IDLE, RUN, FIN.
REQ-013 IDLE->RUN when START=1. RUN->FIN on the transfer with idx=15 in the final pass. FIN->IDLE unconditionally after one cycle.
REQ-014 SHALL assert VALID in the cycle after START is accepted, with idx=0 and pass=0 (latency 1).
REQ-015 In RUN, A SHALL equal table[idx] and B SHALL equal table[(idx+STRIDE) mod 16]; both registered.
REQ-016 Transfer SHALL occur when VALID and READY are both 1; idx advances the next cycle, giving 1 pair/cycle throughput.
REQ-017 While VALID=1 and READY=0, A, B and LAST SHALL hold stable, with no skipped or repeated pair.
REQ-018 idx SHALL wrap 15->0 and increment pass; the sweep ends after NPASS passes.
REQ-019 LAST SHALL be 1 only with idx=15 in pass NPASS-1.
REQ-020 BUSY SHALL be 1 in RUN and FIN; DONE SHALL be a one-cycle pulse in FIN; VALID SHALL be 0 outside RUN.
REQ-021 CSUM SHALL clear to 0 when START is accepted, then add (A+B) on each transfer, all arithmetic mod 256; it holds after FIN.
REQ-022 WR_EN in IDLE SHALL write WR_DATA to [WR_ROW][WR_COL], visible from the next cycle.
REQ-023 WR_EN in RUN or FIN SHALL be dropped and SHALL pulse WR_ERR for one cycle.
REQ-024 START outside IDLE SHALL be ignored.
REQ-025 START and WR_EN together in IDLE: the write SHALL complete first, and the sweep SHALL use the new value.

Reset
REQ-026 RST SHALL take priority over all inputs, including mid-sweep.
REQ-027 Reset values: state IDLE, idx 0, pass 0, A=0, B=0, VALID=0, LAST=0, BUSY=0, DONE=0, CSUM=0, WR_ERR=0.
REQ-028 Reset SHALL restore the table to r*4+c, discarding prior writes.

Structure
REQ-029 A shared package SHALL define the uint8 typedef, the 4x4 table typedef, constants ROWS=4, COLS=4, NENT=16, and the FSM state enum.
REQ-030 Table storage SHALL be sub-module operand_table: a 4x4 register file with reset init, one write port and two combinational read ports.

Verification
REQ-031 Reset, START, READY=1: pairs (0,1),(1,2)...(14,15),(15,0); LAST on the 16th pair; DONE the next cycle; CSUM=240.
REQ-032 READY=0 for 3 cycles while the (2,3) pair is presented: A=2 and B=3 held, VALID=1; the sequence then resumes with (3,4); CSUM=240.
REQ-033 In IDLE, write [1][2]=200, then run: idx5 gives (5,200), idx6 gives (200,7); CSUM=116.
REQ-034 WR_EN to [0][0]=99 during RUN: WR_ERR pulses once, and the next sweep still starts with (0,1).
REQ-035 RST asserted after 7 transfers: the next cycle shows VALID=0, BUSY=0, CSUM=0, and an earlier write is lost (table back to r*4+c).
REQ-036 NPASS=2, READY=1: 32 transfers, LAST only on the 32nd, CSUM=224, one DONE pulse.
